lut_config_loader: RTL and testbench

LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

---
 rtl/lut_config_loader.sv | 155 +++++++++++++++
 tb/tb_lut_config_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// lut_config_loader
//   Receives a serial configuration frame for a chained pair of LUTs, checks
//   it against an even-parity bit, and writes it downstream with a one-cycle
//   strobe. The frame is CFG_WIDTH data bits sent MSB-first, followed by one
//   parity bit. The first bit received ends up in the upper (first-stage)
//   LUT half.
//
// Ports
//   config_clk   : sole clock; all state changes on its rising edge
//   config_rst_n : asynchronous active-low reset
//   start        : begin, or restart, reception of a frame
//   bit_in       : serial data bit
//   bit_valid    : bit_in is offered this cycle
//   bit_ready    : a bit is accepted this cycle (SHIFT and PARITY only)
//   config_en    : one-cycle write strobe to the downstream LUT pair
//   config_out   : last good frame; drives downstream config_in
//   busy         : frame in progress (SHIFT, PARITY, LOAD)
//   done         : last frame loaded; held until the next start
//   error        : last frame failed parity; held until the next start

module lut_config_loader #(
  parameter int INPUTS    = 4,
  parameter int MEM_SIZE  = 2**INPUTS,
  parameter int CFG_WIDTH = 2*MEM_SIZE
) (
  input  logic                 config_clk,
  input  logic                 config_rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic                 config_en,
  output logic [CFG_WIDTH-1:0] config_out,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Counter holds 0..CFG_WIDTH without wrapping.
  localparam int             CNT_W = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    LOAD   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [CFG_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]     cnt;
  logic                 par;        // running XOR of accepted data bits

  // Decoded datapath controls from the FSM.
  logic clr;    // clear shift register, counter and running parity
  logic take;   // accept a data bit into the shift register
  logic load;   // capture shift register into config_out (entry to LOAD)

  // State register.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state, datapath controls and outputs.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    take      = 1'b0;
    load      = 1'b0;
    bit_ready = 1'b0;
    config_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    unique case (state)
      IDLE, DONE, ERROR: begin
        done  = (state == DONE);
        error = (state == ERROR);
        if (start) begin
          state_nxt = SHIFT;
          clr       = 1'b1;
        end
      end

      SHIFT: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        // A restart wins over any bit offered in the same cycle.
        if (start) begin
          clr = 1'b1;
        end else if (bit_valid) begin
          take = 1'b1;
          if (cnt == LAST) state_nxt = PARITY;
        end
      end

      PARITY: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (start) begin
          state_nxt = SHIFT;
          clr       = 1'b1;
        end else if (bit_valid) begin
          // Even parity: data bits XOR parity bit must be zero.
          if (par ^ bit_in) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = LOAD;
            load      = 1'b1;
          end
        end
      end

      LOAD: begin
        busy      = 1'b1;
        config_en = 1'b1;
        state_nxt = DONE;   // start is ignored here
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame assembly. Bits shift in at the LSB so the first bit ends at the MSB.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (clr) begin
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else if (take) begin
      shreg <= {shreg[CFG_WIDTH-2:0], bit_in};
      cnt   <= cnt + 1'b1;
      par   <= par ^ bit_in;
    end
  end

  // config_out only changes when a parity-good frame enters LOAD, so an
  // aborted or failed frame leaves the previously loaded value in place.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n)  config_out <= '0;
    else if (load)      config_out <= shreg;
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader (CFG_WIDTH = 32). Expected frames are
// queued when a good frame is sent and popped by a monitor on config_en.

module tb_lut_config_loader;

  localparam int W = 32;

  logic         config_clk;
  logic         config_rst_n;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic         config_en;
  logic [W-1:0] config_out;
  logic         busy;
  logic         done;
  logic         error;

  lut_config_loader dut (
    .config_clk   (config_clk),
    .config_rst_n (config_rst_n),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .config_en    (config_en),
    .config_out   (config_out),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial config_clk = 1'b0;
  always #5 config_clk = ~config_clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           en_pulses = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {busy, done, error, bit_ready, config_en}
  function automatic logic [31:0] flags();
    return 32'({busy, done, error, bit_ready, config_en});
  endfunction

  // Scoreboard monitor: every write strobe must match a queued good frame.
  always @(negedge config_clk) begin
    if (config_rst_n === 1'b1 && config_en === 1'b1) begin
      en_pulses++;
      chk("config_en_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("config_out_on_en", config_out, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge config_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one bit, optionally after a random idle gap, and hold it until accepted.
  task automatic send_bit(input logic b, input bit gaps);
    int guard;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      bit_valid = 1'b0;
      repeat (g) tick();
    end
    bit_valid = 1'b1;
    bit_in    = b;
    guard     = 0;
    while (bit_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("bit_ready_timeout", 32'd0, 32'd1);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_data(input logic [W-1:0] d, input int nbits, input bit gaps);
    for (int i = W - 1; i >= W - nbits; i--) send_bit(d[i], gaps);
  endtask

  logic [W-1:0] prev_out;
  int           pulses_before;

  initial begin
    start        = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    config_rst_n = 1'b0;
    #12;
    chk("reset_flags", flags(), 32'd0);
    chk("reset_config_out", config_out, 32'd0);
    tick();
    config_rst_n = 1'b1;
    tick();
    chk("idle_flags", flags(), 32'd0);

    // Good frame, continuous valid.
    pulse_start();
    chk("start_flags", flags(), 32'b10010);
    exp_q.push_back(32'hA5A50F0F);
    send_data(32'hA5A50F0F, W, 1'b0);
    chk("parity_state_flags", flags(), 32'b10010);
    send_bit(1'b0, 1'b0);
    chk("load_flags", flags(), 32'b10001);
    chk("load_config_out", config_out, 32'hA5A50F0F);
    tick();
    chk("done_flags", flags(), 32'b01000);
    tick();
    chk("done_hold_flags", flags(), 32'b01000);

    // Bad parity: error, no strobe, config_out held.
    pulses_before = en_pulses;
    prev_out      = config_out;
    pulse_start();
    chk("restart_clears_done", 32'(done), 32'd0);
    send_data(32'hA5A50F0F, W, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("error_flags", flags(), 32'b00100);
    chk("error_config_out_held", config_out, prev_out);
    repeat (3) tick();
    chk("error_hold_flags", flags(), 32'b00100);
    chk("error_no_en", 32'(en_pulses), 32'(pulses_before));

    // Good frame with random valid gaps.
    pulses_before = en_pulses;
    pulse_start();
    chk("start_clears_error", 32'(error), 32'd0);
    exp_q.push_back(32'h12345678);
    send_data(32'h12345678, W, 1'b1);
    send_bit(1'b1, 1'b1);
    chk("stall_load_out", config_out, 32'h12345678);
    repeat (2) tick();
    chk("stall_done_flags", flags(), 32'b01000);
    chk("stall_one_pulse", 32'(en_pulses), 32'(pulses_before + 1));

    // Abort after 10 bits; the bit offered with start must be discarded.
    pulses_before = en_pulses;
    pulse_start();
    send_data(32'hFFC00000, 10, 1'b0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("abort_flags", flags(), 32'b10010);
    chk("abort_out_held", config_out, 32'h12345678);
    exp_q.push_back(32'h00000001);
    send_data(32'h00000001, W, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("abort_load_out", config_out, 32'h00000001);
    tick();
    chk("abort_done_flags", flags(), 32'b01000);
    chk("abort_one_pulse", 32'(en_pulses), 32'(pulses_before + 1));

    // Back-to-back frame after done.
    pulses_before = en_pulses;
    pulse_start();
    chk("b2b_done_cleared", flags(), 32'b10010);
    exp_q.push_back(32'hFFFFFFFF);
    send_data(32'hFFFFFFFF, W, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("b2b_load_flags", flags(), 32'b10001);
    chk("b2b_load_out", config_out, 32'hFFFFFFFF);
    tick();
    chk("b2b_done_flags", flags(), 32'b01000);
    chk("b2b_pulses", 32'(en_pulses), 32'(pulses_before + 1));

    // Async reset during bit 20.
    pulses_before = en_pulses;
    pulse_start();
    send_data(32'hFFFFFFFF, 19, 1'b0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    config_rst_n = 1'b0;
    #1;
    chk("async_reset_flags", flags(), 32'd0);
    chk("async_reset_out", config_out, 32'd0);
    tick();
    config_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_ignored", flags(), 32'd0);
    end
    bit_valid = 1'b0;
    chk("post_reset_out", config_out, 32'd0);
    chk("post_reset_no_en", 32'(en_pulses), 32'(pulses_before));

    chk("total_pulses", 32'(en_pulses), 32'd4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
